// File: rtl/uart_rx_fifo_core_if.sv
//------------------------------------------------------------------------------
// Module  : uart_rx_fifo_core_if
// Brief   : RX FIFO read-side bundle between the UART RX core and the APB slice.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface uart_rx_fifo_core_if #(
    parameter int FIFO_DEPTH = 16
);
    logic                          rd_en_i;
    logic                          fifo_clr_i;
    logic                          ovr_clr_i;
    logic [7:0]                    rd_data_o;
    logic                          rd_pe_o;
    logic                          rd_fe_o;
    logic                          rd_bi_o;
    logic                          rx_valid_o;
    logic [$clog2(FIFO_DEPTH):0]   fifo_level_o;
    logic                          overrun_o;
    logic                          timeout_o;

    modport master (
        output rd_en_i, fifo_clr_i, ovr_clr_i,
        input  rd_data_o, rd_pe_o, rd_fe_o, rd_bi_o, rx_valid_o,
               fifo_level_o, overrun_o, timeout_o
    );

    modport slave (
        input  rd_en_i, fifo_clr_i, ovr_clr_i,
        output rd_data_o, rd_pe_o, rd_fe_o, rd_bi_o, rx_valid_o,
               fifo_level_o, overrun_o, timeout_o
    );
endinterface

`default_nettype wire

// File: rtl/uart_rx_fifo_core.sv
//------------------------------------------------------------------------------
// Module  : uart_rx_fifo_core
// Brief   : Oversampling UART deframer feeding a FWFT RX FIFO with error flags.
//           Optional character timeout enabled by macro UART_RX_TIMEOUT_EN.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module uart_rx_fifo_core #(
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_W      = 16
) (
    input  wire logic             clk_i,
    input  wire logic             rst_n_i,
    input  wire logic [DIV_W-1:0] baud_div_i,
    input  wire logic [1:0]       cfg_wls_i,
    input  wire logic             cfg_stb_i,
    input  wire logic             cfg_pen_i,
    input  wire logic             cfg_eps_i,
    input  wire logic             uart_rx_i,
    uart_rx_fifo_core_if.slave    rd_if
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int OW = $clog2(OVERSAMPLE);
    localparam int EW = 11;

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH
    } state_t;

    // Synchroniser resets to idle-high so release of reset cannot fake a start bit
    logic [1:0]       sync_q, sync_d;
    logic             rx_s;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d, div_last;
    logic             tick;

    always_comb begin
        sync_d    = {sync_q[0], uart_rx_i};
        rx_s      = sync_q[1];
        div_last  = (baud_div_i == '0) ? '0 : baud_div_i - 1'b1;
        tick      = (div_cnt_q >= div_last);
        div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            sync_q    <= 2'b11;
            div_cnt_q <= '0;
        end else begin
            sync_q    <= sync_d;
            div_cnt_q <= div_cnt_d;
        end
    end

    state_t          state_q;
    logic [OW-1:0]   os_cnt_q, samp_pt;
    logic            samp;
    logic [2:0]      bit_idx_q;
    logic [7:0]      shift_q;
    logic            par_q, pe_q;
    logic [1:0]      wls_q;
    logic            stb_q, pen_q, eps_q;
    logic            push_q;
    logic [EW-1:0]   push_data_q;

    always_comb begin
        samp_pt = (state_q == S_START) ? OW'(OVERSAMPLE/2 - 1) : OW'(OVERSAMPLE - 1);
        samp    = tick && (os_cnt_q == samp_pt);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q     <= S_IDLE;
            os_cnt_q    <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            par_q       <= 1'b0;
            pe_q        <= 1'b0;
            wls_q       <= '0;
            stb_q       <= 1'b0;
            pen_q       <= 1'b0;
            eps_q       <= 1'b0;
            push_q      <= 1'b0;
            push_data_q <= '0;
        end else begin
            push_q <= 1'b0;
            if (tick && (state_q inside {S_START, S_DATA, S_PARITY, S_STOP}))
                os_cnt_q <= samp ? '0 : os_cnt_q + 1'b1;
            case (state_q)
                S_IDLE: if (!rx_s) begin
                    state_q   <= S_START;
                    os_cnt_q  <= '0;
                    bit_idx_q <= '0;
                    shift_q   <= '0;
                    par_q     <= 1'b0;
                    pe_q      <= 1'b0;
                    wls_q     <= cfg_wls_i;
                    stb_q     <= cfg_stb_i;
                    pen_q     <= cfg_pen_i;
                    eps_q     <= cfg_eps_i;
                end
                S_START: if (samp) state_q <= rx_s ? S_IDLE : S_DATA;
                S_DATA: if (samp) begin
                    shift_q[bit_idx_q] <= rx_s;
                    bit_idx_q          <= bit_idx_q + 1'b1;
                    // last data bit index is word length - 1 = wls + 4
                    if (bit_idx_q == {1'b1, wls_q})
                        state_q <= pen_q ? S_PARITY : S_STOP;
                end
                S_PARITY: if (samp) begin
                    par_q   <= rx_s;
                    pe_q    <= (((^shift_q) ^ rx_s) == eps_q);
                    state_q <= S_STOP;
                end
                S_STOP: if (samp) begin
                    push_q      <= 1'b1;
                    push_data_q <= {(shift_q == '0) && !par_q && !rx_s, !rx_s, pe_q, shift_q};
                    state_q     <= rx_s ? S_IDLE : S_WAIT_HIGH;
                end
                S_WAIT_HIGH: if (rx_s) state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    logic [EW-1:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   count_q, count_d;
    logic            ovr_q, ovr_d;
    logic            full, empty, pop, wr;
    logic [EW-1:0]   head;

    always_comb begin
        full  = (count_q == LW'(FIFO_DEPTH));
        empty = (count_q == '0);
        pop   = rd_if.rd_en_i && !empty;
        wr    = push_q && (!full || pop) && !rd_if.fifo_clr_i;
        head  = empty ? '0 : mem_q[rd_ptr_q];
        if (rd_if.fifo_clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            wr_ptr_d = wr_ptr_q + AW'(wr);
            rd_ptr_d = rd_ptr_q + AW'(pop);
            count_d  = count_q + LW'(wr) - LW'(pop);
        end
        // a push lost to a flush is not an overrun
        if (push_q && full && !pop && !rd_if.fifo_clr_i)
            ovr_d = 1'b1;
        else if (rd_if.ovr_clr_i)
            ovr_d = 1'b0;
        else
            ovr_d = ovr_q;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovr_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovr_q    <= ovr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr) mem_q[wr_ptr_q] <= push_data_q;
    end

    assign rd_if.rd_data_o    = head[7:0];
    assign rd_if.rd_pe_o      = head[8];
    assign rd_if.rd_fe_o      = head[9];
    assign rd_if.rd_bi_o      = head[10];
    assign rd_if.rx_valid_o   = !empty;
    assign rd_if.fifo_level_o = count_q;
    assign rd_if.overrun_o    = ovr_q;

`ifdef UART_RX_TIMEOUT_EN
    localparam int TW = $clog2(48*OVERSAMPLE + 1);
    logic [TW-1:0] to_cnt_q, to_cnt_d, to_lim;
    logic [3:0]    frame_bits;

    always_comb begin
        frame_bits = 4'd7 + {2'b00, wls_q} + {3'b000, pen_q} + {3'b000, stb_q};
        to_lim     = TW'(frame_bits) * TW'(4*OVERSAMPLE);
        if (push_q || pop || rd_if.fifo_clr_i || empty)
            to_cnt_d = '0;
        else if (tick && (to_cnt_q < to_lim))
            to_cnt_d = to_cnt_q + 1'b1;
        else
            to_cnt_d = to_cnt_q;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) to_cnt_q <= '0;
        else          to_cnt_q <= to_cnt_d;
    end

    assign rd_if.timeout_o = (to_cnt_q >= to_lim);
`else
    logic unused_stb;
    assign unused_stb      = stb_q;
    assign rd_if.timeout_o = 1'b0;
`endif

endmodule

`default_nettype wire
